// File: rtl/riscv_imem_resp_pkg.sv
// riscv_constants: constants and the response record shared by the
// instruction-memory responder pipeline and its response FIFO.
//   IMEM_NOP  : instruction returned for a faulting fetch (addi x0,x0,0)
//   IMEM_RSP  : {inst, addr, err} record carried through pipeline and FIFO
package riscv_constants;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } IMEM_RSP;

endpackage

// File: rtl/riscv_imem_rsp_fifo.sv
// riscv_imem_rsp_fifo: ordered response FIFO with a registered head.
// The head is taken straight from the storage registers, so an entry pushed
// in one cycle becomes visible at the head in the next.
// Ports:
//   clk, x_reset      clock, asynchronous active-low reset
//   flush             synchronous clear of pointers and occupancy
//   push, push_data   write one IMEM_RSP entry
//   pop               remove the head entry (ignored when empty)
//   head              current head entry, all-zero when empty
//   empty, full       occupancy flags
module riscv_imem_rsp_fifo
    import riscv_constants::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    x_reset,
    input  logic    flush,
    input  logic    push,
    input  IMEM_RSP push_data,
    input  logic    pop,
    output IMEM_RSP head,
    output logic    empty,
    output logic    full
);

    localparam int PW = $clog2(DEPTH);

    IMEM_RSP          store [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      occ;
    logic             push_eff;
    logic             pop_eff;

    assign empty    = (occ == '0);
    assign full     = (occ == (PW+1)'(DEPTH));
    assign pop_eff  = pop && !empty;
    // Writing while full is only safe when the head leaves in the same cycle.
    assign push_eff = push && (!full || pop_eff);

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push_eff) wptr <= wptr + PW'(1);
            if (pop_eff)  rptr <= rptr + PW'(1);
            case ({push_eff, pop_eff})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff && !flush) store[wptr] <= push_data;
    end

    assign head = empty ? '0 : store[rptr];

endmodule

// File: rtl/riscv_imem_resp.sv
// riscv_imem_resp: instruction-memory responder at the far end of the fetch
// interface. Fetch requests read a synchronous word RAM through a LATENCY
// cycle pipeline and return {inst, addr, err} in order through a response
// FIFO. A program-load port writes the RAM (read-first on collisions).
// Build option: define RISCV_IMEM_ERR_EN to flag misaligned or out-of-range
// fetches with rsp_err=1 and a NOP instruction; otherwise rsp_err is 0 and
// addresses wrap modulo WORDS*4.
// Ports:
//   clk, x_reset                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr      fetch request handshake and PC
//   flush                             PC redirect, drops all outstanding work
//   rsp_valid/rsp_ready               response handshake
//   rsp_inst/rsp_addr/rsp_err         response payload
//   wr_en/wr_addr/wr_data             program-load write port
module riscv_imem_resp
    import riscv_constants::*;
#(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          req_err;
    logic          accept;
    logic          pop;
    logic [CW-1:0] count;

    logic          vld_p [LATENCY];
    IMEM_RSP       rsp_p [LATENCY];
    IMEM_RSP       push_rsp;
    IMEM_RSP       head;
    logic          fifo_empty;
    logic          unused_fifo_full;
    logic          unused_wr_bits;

    assign rd_idx = req_addr[AW+1:2];
    assign wr_idx = wr_addr[AW+1:2];
    assign unused_wr_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};

`ifdef RISCV_IMEM_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(WORDS) << 2;
    assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
`else
    assign req_err = 1'b0;
`endif

    // Credits cover the pipeline as well as the FIFO, so a push never finds
    // the FIFO full without a matching pop.
    assign req_ready = (count < CW'(DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p0: RAM read (read-first against a same-cycle write), then
    // LATENCY-1 plain register stages towards the FIFO.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        if (accept) begin
            rsp_p[0].inst <= mem[rd_idx];
            rsp_p[0].addr <= req_addr;
            rsp_p[0].err  <= req_err;
        end
        for (int i = 1; i < LATENCY; i++) begin
            rsp_p[i] <= rsp_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Last stage boundary: faulting fetches are replaced by a NOP here.
    always_comb begin
        push_rsp      = rsp_p[LATENCY-1];
        push_rsp.inst = rsp_p[LATENCY-1].err ? IMEM_NOP : rsp_p[LATENCY-1].inst;
    end

    riscv_imem_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .x_reset   (x_reset),
        .flush     (flush),
        .push      (vld_p[LATENCY-1]),
        .push_data (push_rsp),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (unused_fifo_full)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_inst  = head.inst;
    assign rsp_addr  = head.addr;
    assign rsp_err   = head.err;

endmodule
